dds_sweep_ctrl: RTL and testbench

Sequencer for the two-DDS / multiplier / FIR datapath. It holds a software-written shadow configuration: FIR coefficients, DDS1 start increment and step, DDS2 increment, dwell and step count. On `start` it loads the coefficients into the FIR and flushes the filter with the DDS held in reset. It then runs a stepped frequency sweep on DDS1 while DDS2 stays fixed, and signals completion.

---
 rtl/dds_sweep_ctrl_if.sv | 16 +
 rtl/dds_sweep_ctrl.sv | 130 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// Configuration/control bus between software-facing logic and the sweep sequencer.
// The master writes shadow registers and issues start/abort; the slave reports busy/done.
interface dds_sweep_ctrl_if #(
   parameter int PHASE_W = 16
);
   logic               cfg_we;
   logic [3:0]         cfg_addr;
   logic [PHASE_W-1:0] cfg_data;
   logic               start;
   logic               abort;
   logic               busy;
   logic               done;

   modport master (output cfg_we, cfg_addr, cfg_data, start, abort, input busy, done);
   modport slave  (input cfg_we, cfg_addr, cfg_data, start, abort, output busy, done);
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Sweep sequencer: loads FIR coefficients, flushes the filter with the DDS held
// in reset, then steps DDS1 through nsteps increments of dwell cycles each.
module dds_sweep_ctrl #(
   parameter int PHASE_W = 16,
   parameter int COEF_W  = 8,
   parameter int NTAPS   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   dds_sweep_ctrl_if.slave          bus,
   output logic                     dds_rst,
   output logic                     dds_en,
   output logic [PHASE_W-1:0]       dds1_inc,
   output logic [PHASE_W-1:0]       dds2_inc,
   output logic                     coef_we,
   output logic [$clog2(NTAPS)-1:0] coef_addr,
   output logic [COEF_W-1:0]        coef_data,
   output logic                     fir_flush,
   output logic [7:0]               step_idx
);
   localparam int         AW       = $clog2(NTAPS);
   localparam logic [7:0] TAP_LAST = 8'(NTAPS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE} state_t;

   state_t                      state, nxt;
   logic [7:0]                  cnt;
   logic [NTAPS-1:0][COEF_W-1:0] s_coef, w_coef;
   logic [PHASE_W-1:0]          s_start, s_step, s_dds2;
   logic [PHASE_W-1:0]          w_start, w_step, w_dds2;
   logic [7:0]                  s_nsteps, s_dwell, w_nsteps, w_dwell;
   logic                        last_tap, dwell_end, last_step;

   assign last_tap  = (cnt == TAP_LAST);
   assign dwell_end = (cnt == w_dwell - 8'd1);
   assign last_step = (step_idx == w_nsteps - 8'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (bus.start) nxt = LOAD;
         LOAD:    if (last_tap) nxt = FLUSH;
         FLUSH:   if (last_tap) nxt = RUN;
         RUN:     if (dwell_end && last_step) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      // abort wins everywhere, including over a start seen in IDLE
      if (bus.abort) nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         s_coef   <= '0;
         w_coef   <= '0;
         s_start  <= '0;
         s_step   <= '0;
         s_dds2   <= '0;
         w_start  <= '0;
         w_step   <= '0;
         w_dds2   <= '0;
         s_nsteps <= '0;
         s_dwell  <= '0;
         w_nsteps <= '0;
         w_dwell  <= '0;
         dds1_inc <= '0;
         dds2_inc <= '0;
         step_idx <= '0;
      end else begin
         if (state == IDLE && bus.cfg_we) begin
            if (int'(bus.cfg_addr) < NTAPS)
               s_coef[bus.cfg_addr[AW-1:0]] <= bus.cfg_data[COEF_W-1:0];
            else begin
               case (bus.cfg_addr)
                  4'd12: s_start <= bus.cfg_data;
                  4'd13: s_step  <= bus.cfg_data;
                  4'd14: s_dds2  <= bus.cfg_data;
                  4'd15: {s_nsteps, s_dwell} <= bus.cfg_data[15:0];
                  default: ;
               endcase
            end
         end
         case (state)
            IDLE: if (nxt == LOAD) begin
               // zero-length fields run as a single cycle / single step
               w_coef   <= s_coef;
               w_start  <= s_start;
               w_step   <= s_step;
               w_dds2   <= s_dds2;
               w_nsteps <= (s_nsteps == 8'd0) ? 8'd1 : s_nsteps;
               w_dwell  <= (s_dwell == 8'd0) ? 8'd1 : s_dwell;
               cnt      <= '0;
            end
            LOAD: cnt <= last_tap ? 8'd0 : cnt + 8'd1;
            FLUSH: begin
               cnt <= last_tap ? 8'd0 : cnt + 8'd1;
               if (nxt == RUN) begin
                  dds1_inc <= w_start;
                  dds2_inc <= w_dds2;
                  step_idx <= '0;
               end
            end
            RUN: if (nxt == RUN) begin
               if (dwell_end) begin
                  cnt      <= '0;
                  step_idx <= step_idx + 8'd1;
                  dds1_inc <= dds1_inc + w_step;
               end else
                  cnt <= cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy  = (state != IDLE);
   assign bus.done  = (state == DONE);
   assign dds_rst   = (state != RUN);
   assign dds_en    = (state == RUN);
   assign fir_flush = (state == FLUSH);
   assign coef_we   = (state == LOAD);
   assign coef_addr = coef_we ? cnt[AW-1:0] : '0;
   assign coef_data = coef_we ? w_coef[cnt[AW-1:0]] : '0;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: reset, coefficient load, sweep, wrap,
// abort/ignore rules and asynchronous reset mid-sequence.
module tb_dds_sweep_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        dds_rst, dds_en, coef_we, fir_flush;
   logic [15:0] dds1_inc, dds2_inc;
   logic [2:0]  coef_addr;
   logic [7:0]  coef_data, step_idx;
   int          checks = 0;
   int          errors = 0;

   dds_sweep_ctrl_if #(.PHASE_W(16)) bus();

   dds_sweep_ctrl #(.PHASE_W(16), .COEF_W(8), .NTAPS(8)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .dds_rst(dds_rst), .dds_en(dds_en), .dds1_inc(dds1_inc), .dds2_inc(dds2_inc),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .fir_flush(fir_flush), .step_idx(step_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic write_cfg(input logic [3:0] a, input logic [15:0] d);
      bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
      tick();
      bus.cfg_we = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) tick();
      checks++;
      if ({dds_rst, dds_en, coef_we, fir_flush, bus.busy, bus.done} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctl: got %b want 100000",
                  {dds_rst, dds_en, coef_we, fir_flush, bus.busy, bus.done});
      end
      checks++;
      if ({dds1_inc, dds2_inc, step_idx, coef_addr, coef_data} !== '0) begin
         errors++;
         $display("FAIL reset_data: dds1 %h dds2 %h step %h addr %h data %h want all 0",
                  dds1_inc, dds2_inc, step_idx, coef_addr, coef_data);
      end
      rst = 1'b1;
      tick();
      pulse_start();
      // defaults: dwell=1, nsteps=1 -> 8+8+1+1 = 18 busy cycles
      for (int c = 1; c <= 19; c++) begin
         checks++;
         if (bus.busy !== (c <= 18) || bus.done !== (c == 18)) begin
            errors++;
            $display("FAIL reset_run c%0d: busy %b done %b want %b %b",
                     c, bus.busy, bus.done, c <= 18, c == 18);
         end
         if (c == 17) begin
            checks++;
            if (dds_en !== 1'b1 || dds1_inc !== 16'h0 || step_idx !== 8'd0) begin
               errors++;
               $display("FAIL reset_run_step: en %b dds1 %h step %0d want 1 0000 0",
                        dds_en, dds1_inc, step_idx);
            end
         end
         tick();
      end
   endtask

   task automatic test_coef_load();
      int n;
      for (int k = 0; k < 8; k++) write_cfg(4'(k), 16'(k + 1));
      pulse_start();
      for (int c = 1; c <= 17; c++) begin
         checks++;
         if (c <= 8) begin
            if (coef_we !== 1'b1 || coef_addr !== 3'(c - 1) || coef_data !== 8'(c) ||
                fir_flush !== 1'b0 || dds_rst !== 1'b1) begin
               errors++;
               $display("FAIL coef_load c%0d: we %b addr %0d data %0d flush %b want 1 %0d %0d 0",
                        c, coef_we, coef_addr, coef_data, fir_flush, c - 1, c);
            end
         end else if (c <= 16) begin
            if (fir_flush !== 1'b1 || dds_rst !== 1'b1 || coef_we !== 1'b0 || dds_en !== 1'b0) begin
               errors++;
               $display("FAIL coef_flush c%0d: flush %b rst %b we %b en %b want 1 1 0 0",
                        c, fir_flush, dds_rst, coef_we, dds_en);
            end
         end else begin
            if (fir_flush !== 1'b0 || dds_en !== 1'b1 || dds_rst !== 1'b0) begin
               errors++;
               $display("FAIL coef_run: flush %b en %b rst %b want 0 1 0", fir_flush, dds_en, dds_rst);
            end
         end
         tick();
      end
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL coef_idle_timeout: busy %b want 0", bus.busy);
      end
   endtask

   task automatic test_sweep();
      int k;
      write_cfg(4'd12, 16'h0100);
      write_cfg(4'd13, 16'h0040);
      write_cfg(4'd14, 16'h0200);
      write_cfg(4'd15, 16'h0304);
      pulse_start();
      for (int c = 1; c <= 32; c++) begin
         checks++;
         if (bus.busy !== (c <= 29 || c == 31) || bus.done !== (c == 29)) begin
            errors++;
            $display("FAIL sweep_busy c%0d: busy %b done %b want %b %b",
                     c, bus.busy, bus.done, c <= 29 || c == 31, c == 29);
         end
         if (c >= 17 && c <= 28) begin
            k = (c - 17) / 4;
            checks++;
            if (dds1_inc !== 16'(16'h0100 + 16'h0040 * k) || step_idx !== 8'(k) ||
                dds2_inc !== 16'h0200 || dds_en !== 1'b1) begin
               errors++;
               $display("FAIL sweep_step c%0d: dds1 %h step %0d dds2 %h en %b want %h %0d 0200 1",
                        c, dds1_inc, step_idx, dds2_inc, dds_en, 16'(16'h0100 + 16'h0040 * k), k);
            end
         end
         if (c == 31) begin
            checks++;
            if (coef_we !== 1'b1 || coef_addr !== 3'd0) begin
               errors++;
               $display("FAIL back_to_back: we %b addr %0d want 1 0", coef_we, coef_addr);
            end
         end
         bus.start = (c == 30);
         bus.abort = (c == 31);
         tick();
      end
      bus.start = 1'b0; bus.abort = 1'b0;
   endtask

   task automatic test_wrap();
      write_cfg(4'd12, 16'hFFE0);
      write_cfg(4'd15, 16'h0202);
      pulse_start();
      for (int c = 1; c <= 22; c++) begin
         checks++;
         if (bus.busy !== (c <= 21) || bus.done !== (c == 21)) begin
            errors++;
            $display("FAIL wrap_busy c%0d: busy %b done %b want %b %b",
                     c, bus.busy, bus.done, c <= 21, c == 21);
         end
         if (c >= 17 && c <= 20) begin
            checks++;
            if (dds1_inc !== ((c >= 19) ? 16'h0020 : 16'hFFE0)) begin
               errors++;
               $display("FAIL wrap_inc c%0d: dds1 %h want %h", c, dds1_inc,
                        (c >= 19) ? 16'h0020 : 16'hFFE0);
            end
         end
         tick();
      end
   endtask

   task automatic test_abort_ignore();
      write_cfg(4'd12, 16'h0100);
      write_cfg(4'd15, 16'h0304);
      bus.start = 1'b1; bus.abort = 1'b1;
      tick();
      bus.start = 1'b0; bus.abort = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || coef_we !== 1'b0) begin
         errors++;
         $display("FAIL abort_priority: busy %b we %b want 0 0", bus.busy, coef_we);
      end
      pulse_start();
      for (int c = 1; c <= 26; c++) begin
         checks++;
         if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone c%0d: done %b want 0", c, bus.done);
         end
         if (c == 19) begin
            checks++;
            if (bus.busy !== 1'b1 || dds_en !== 1'b1 || coef_we !== 1'b0 || step_idx !== 8'd0) begin
               errors++;
               $display("FAIL start_ignored: busy %b en %b we %b step %0d want 1 1 0 0",
                        bus.busy, dds_en, coef_we, step_idx);
            end
         end
         if (c == 22) begin
            checks++;
            if (step_idx !== 8'd1 || dds1_inc !== 16'h0140) begin
               errors++;
               $display("FAIL abort_pre: step %0d dds1 %h want 1 0140", step_idx, dds1_inc);
            end
         end
         if (c >= 23) begin
            checks++;
            if (bus.busy !== 1'b0 || dds_rst !== 1'b1 || dds_en !== 1'b0 || dds1_inc !== 16'h0140) begin
               errors++;
               $display("FAIL abort_post c%0d: busy %b rst %b en %b dds1 %h want 0 1 0 0140",
                        c, bus.busy, dds_rst, dds_en, dds1_inc);
            end
         end
         bus.start    = (c == 18);
         bus.cfg_we   = (c == 18);
         bus.cfg_addr = 4'd12;
         bus.cfg_data = 16'h5555;
         bus.abort    = (c == 22);
         tick();
      end
      bus.start = 1'b0; bus.cfg_we = 1'b0; bus.abort = 1'b0;
      pulse_start();
      repeat (16) tick();
      checks++;
      if (dds1_inc !== 16'h0100) begin
         errors++;
         $display("FAIL busy_write_dropped: dds1 %h want 0100", dds1_inc);
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
   endtask

   task automatic test_async_reset();
      pulse_start();
      repeat (11) tick();
      #2 rst = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || dds_rst !== 1'b1 || fir_flush !== 1'b0 || dds_en !== 1'b0 ||
          bus.done !== 1'b0 || dds1_inc !== 16'h0 || dds2_inc !== 16'h0 || step_idx !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: busy %b rst %b flush %b en %b done %b dds1 %h dds2 %h step %0d",
                  bus.busy, dds_rst, fir_flush, dds_en, bus.done, dds1_inc, dds2_inc, step_idx);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
      pulse_start();
      for (int c = 1; c <= 19; c++) begin
         if (c == 1) begin
            checks++;
            if (coef_we !== 1'b1 || coef_data !== 8'd0) begin
               errors++;
               $display("FAIL async_coef_cleared: we %b data %0d want 1 0", coef_we, coef_data);
            end
         end
         if (c == 17) begin
            checks++;
            if (dds_en !== 1'b1 || dds1_inc !== 16'h0 || dds2_inc !== 16'h0) begin
               errors++;
               $display("FAIL async_shadow_cleared: en %b dds1 %h dds2 %h want 1 0000 0000",
                        dds_en, dds1_inc, dds2_inc);
            end
         end
         checks++;
         if (bus.busy !== (c <= 18) || bus.done !== (c == 18)) begin
            errors++;
            $display("FAIL async_rerun c%0d: busy %b done %b want %b %b",
                     c, bus.busy, bus.done, c <= 18, c == 18);
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
      bus.start = 1'b0; bus.abort = 1'b0;
      test_reset();
      test_coef_load();
      test_sweep();
      test_wrap();
      test_abort_ignore();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
